ptw_mem_arbiter: RTL and testbench

- Shares one downstream memory port (CacheReq/CacheResp) between the instruction-side and data-side Sv32 page table walkers.
- Arbitrates requests, locks a grant until the downstream accepts it, and records the requester of each accepted read in a small ID FIFO.
- Routes untagged, in-order responses back to the correct walker.
- Sits between the two walkers' memreq/memresp and the L2/memory interface.

---
 rtl/ptw_mem_arbiter_pkg.sv | 14 +
 rtl/ptw_mem_arbiter_if.sv | 26 ++
 rtl/ptw_mem_arbiter_id.sv | 57 +++++
 rtl/ptw_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_ptw_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ptw_mem_arbiter_pkg.sv
// Shared types and constants for the page-table-walker memory arbiter.
// CacheReq/CacheResp widths live here so the interfaces and logic agree.
package ptw_mem_arbiter_pkg;

   localparam int unsigned AddrW  = 32;
   localparam int unsigned DataW  = 32;
   localparam int unsigned ErrTyW = 2;

   localparam int unsigned ARB_PRIO_RR   = 0;
   localparam int unsigned ARB_PRIO_DATA = 1;

   typedef enum logic {ARB_I = 1'b0, ARB_D = 1'b1} ArbId;

endpackage

// File: rtl/ptw_mem_arbiter_if.sv
// CacheReq (valid/ready request) and CacheResp (untagged, in-order response pulse) channels.
// master drives the channel, slave receives it.
interface cache_req_if;
   import ptw_mem_arbiter_pkg::*;

   logic             valid;
   logic             ready;
   logic [AddrW-1:0] addr;
   logic             wen;
   logic [DataW-1:0] wdata;

   modport master (output valid, output addr, output wen, output wdata, input ready);
   modport slave  (input valid, input addr, input wen, input wdata, output ready);
endinterface

interface cache_resp_if;
   import ptw_mem_arbiter_pkg::*;

   logic              valid;
   logic [DataW-1:0]  rdata;
   logic              error;
   logic [ErrTyW-1:0] errty;

   modport master (output valid, output rdata, output error, output errty);
   modport slave  (input valid, input rdata, input error, input errty);
endinterface

// File: rtl/ptw_mem_arbiter_id.sv
// Requester-ID FIFO: remembers which walker owns each outstanding read.
// Full/empty come from the registered count; no push-to-head bypass.
module ptw_arb_id_fifo
   import ptw_mem_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  ArbId push_id_i,
   input  logic pop_i,
   output logic full_o,
   output logic empty_o,
   output ArbId head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   ArbId            mem_q [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      // Power-of-two depth lets the pointers wrap on overflow.
      if (do_push) wr_ptr_d = (Depth == 1) ? '0 : wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = (Depth == 1) ? '0 : rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_id_i;
   end

endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares one downstream memory port between the I-side and D-side Sv32 walkers.
// Optional PTW_ARB_PERFCNT_EN adds grant/conflict performance counters.
module ptw_mem_arbiter
   import ptw_mem_arbiter_pkg::*;
#(
   parameter int unsigned OUTSTANDING_DEPTH = 2,
   parameter int unsigned PRIORITY_MODE     = ARB_PRIO_RR,
   parameter int unsigned LOG_ENABLE        = 0
) (
   input  logic                clk,
   input  logic                reset,
   cache_req_if.slave          ireq,
   cache_resp_if.master        iresp,
   cache_req_if.slave          dreq,
   cache_resp_if.master        dresp,
   cache_req_if.master         memreq,
   cache_resp_if.slave         memresp,
   output logic                protocol_err
`ifdef PTW_ARB_PERFCNT_EN
   ,
   output logic [31:0]         perf_igrant,
   output logic [31:0]         perf_dgrant,
   output logic [31:0]         perf_conflict
`endif
);

   ArbId sel, head;
   ArbId lock_id_q, lock_id_d, last_q, last_d;
   logic lock_q, lock_d, perr_q, perr_d;
   logic sel_valid, sel_wen, accept, push, pop, fifo_full, fifo_empty;

   // Tracing is a simulation-only aid; the synthesizable body ignores it.
   logic unused_log_en;
   assign unused_log_en = (LOG_ENABLE != 0);

   always_comb begin
      sel = ARB_I;
      if (lock_q) begin
         sel = lock_id_q;
      end else if (ireq.valid && dreq.valid) begin
         if (PRIORITY_MODE == ARB_PRIO_DATA) sel = ARB_D;
         else                                sel = (last_q == ARB_I) ? ARB_D : ARB_I;
      end else if (dreq.valid) begin
         sel = ARB_D;
      end
   end

   assign sel_valid     = (sel == ARB_D) ? dreq.valid : ireq.valid;
   assign sel_wen       = (sel == ARB_D) ? dreq.wen   : ireq.wen;
   assign memreq.addr   = (sel == ARB_D) ? dreq.addr  : ireq.addr;
   assign memreq.wdata  = (sel == ARB_D) ? dreq.wdata : ireq.wdata;
   assign memreq.wen    = sel_wen;
   // Writes bypass the full check: they never produce a response.
   assign memreq.valid  = ~reset & sel_valid & ~(~sel_wen & fifo_full);
   assign accept        = memreq.valid & memreq.ready;
   assign ireq.ready    = accept & (sel == ARB_I);
   assign dreq.ready    = accept & (sel == ARB_D);
   assign push          = accept & ~sel_wen;

   assign pop           = ~reset & memresp.valid & ~fifo_empty;
   assign iresp.valid   = pop & (head == ARB_I);
   assign dresp.valid   = pop & (head == ARB_D);
   assign iresp.rdata   = memresp.rdata;
   assign iresp.error   = memresp.error;
   assign iresp.errty   = memresp.errty;
   assign dresp.rdata   = memresp.rdata;
   assign dresp.error   = memresp.error;
   assign dresp.errty   = memresp.errty;
   assign protocol_err  = perr_q;

   always_comb begin
      lock_d    = memreq.valid & ~memreq.ready;
      lock_id_d = lock_d ? sel : lock_id_q;
      last_d    = accept ? sel : last_q;
      perr_d    = perr_q | (memresp.valid & fifo_empty);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_q    <= 1'b0;
         lock_id_q <= ARB_I;
         last_q    <= ARB_I;
         perr_q    <= 1'b0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         last_q    <= last_d;
         perr_q    <= perr_d;
      end
   end

   ptw_arb_id_fifo #(
      .Depth (OUTSTANDING_DEPTH)
   ) u_id_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_i    (push),
      .push_id_i (sel),
      .pop_i     (pop),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .head_o    (head)
   );

`ifdef PTW_ARB_PERFCNT_EN
   logic [31:0] perf_igrant_q, perf_dgrant_q, perf_conflict_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_igrant_q   <= '0;
         perf_dgrant_q   <= '0;
         perf_conflict_q <= '0;
      end else begin
         if (ireq.ready) perf_igrant_q <= perf_igrant_q + 32'd1;
         if (dreq.ready) perf_dgrant_q <= perf_dgrant_q + 32'd1;
         // With both presenting, at most one can be served this cycle.
         if (ireq.valid && dreq.valid) perf_conflict_q <= perf_conflict_q + 32'd1;
      end
   end

   assign perf_igrant   = perf_igrant_q;
   assign perf_dgrant   = perf_dgrant_q;
   assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: directed scenarios plus a randomized run
// compared against a queue-based reference model of arbitration and response steering.
module tb_ptw_mem_arbiter;
   import ptw_mem_arbiter_pkg::*;

   localparam int unsigned Depth = 2;

   logic clk;
   logic reset;
   logic protocol_err;
   int   checks;
   int   failures;

   cache_req_if  ireq ();
   cache_resp_if iresp ();
   cache_req_if  dreq ();
   cache_resp_if dresp ();
   cache_req_if  memreq ();
   cache_resp_if memresp ();

`ifdef PTW_ARB_PERFCNT_EN
   logic [31:0] perf_igrant, perf_dgrant, perf_conflict;
`endif

   ptw_mem_arbiter #(
      .OUTSTANDING_DEPTH (Depth),
      .PRIORITY_MODE     (ARB_PRIO_RR),
      .LOG_ENABLE        (0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq          (ireq),
      .iresp         (iresp),
      .dreq          (dreq),
      .dresp         (dresp),
      .memreq        (memreq),
      .memresp       (memresp),
      .protocol_err  (protocol_err)
`ifdef PTW_ARB_PERFCNT_EN
      ,
      .perf_igrant   (perf_igrant),
      .perf_dgrant   (perf_dgrant),
      .perf_conflict (perf_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic drive_i(input logic v, input logic [AddrW-1:0] a, input logic w,
                          input logic [DataW-1:0] d);
      ireq.valid = v; ireq.addr = a; ireq.wen = w; ireq.wdata = d;
   endtask

   task automatic drive_d(input logic v, input logic [AddrW-1:0] a, input logic w,
                          input logic [DataW-1:0] d);
      dreq.valid = v; dreq.addr = a; dreq.wen = w; dreq.wdata = d;
   endtask

   task automatic idle_inputs();
      drive_i(1'b0, '0, 1'b0, '0);
      drive_d(1'b0, '0, 1'b0, '0);
      memreq.ready  = 1'b0;
      memresp.valid = 1'b0;
      memresp.rdata = '0;
      memresp.error = 1'b0;
      memresp.errty = '0;
   endtask

   task automatic apply_reset();
      tick();
      reset = 1'b1;
      idle_inputs();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      reset = 1'b1;
      drive_i(1'b1, 32'h8000_1000, 1'b0, '0);
      drive_d(1'b1, 32'h8000_2000, 1'b0, '0);
      memreq.ready = 1'b1;
      memresp.valid = 1'b1;
      settle();
      checks++; if (memreq.valid !== 1'b0) begin failures++; $display("FAIL reset_memreq_valid got=%0b exp=0", memreq.valid); end
      checks++; if (ireq.ready !== 1'b0) begin failures++; $display("FAIL reset_ireq_ready got=%0b exp=0", ireq.ready); end
      checks++; if (dreq.ready !== 1'b0) begin failures++; $display("FAIL reset_dreq_ready got=%0b exp=0", dreq.ready); end
      checks++; if (iresp.valid !== 1'b0 || dresp.valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%0b%0b exp=00", iresp.valid, dresp.valid); end
      tick();
      settle();
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL reset_protocol_err got=%0b exp=0", protocol_err); end
      tick();
      reset = 1'b0;
      idle_inputs();
      settle();
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL post_reset_protocol_err got=%0b exp=0", protocol_err); end
   endtask

   task automatic test_single_read();
      apply_reset();
      tick();
      drive_i(1'b1, 32'h8000_1000, 1'b0, '0);
      memreq.ready = 1'b1;
      settle();
      checks++; if (memreq.valid !== 1'b1) begin failures++; $display("FAIL single_memreq_valid got=%0b exp=1", memreq.valid); end
      checks++; if (memreq.addr !== 32'h8000_1000) begin failures++; $display("FAIL single_memreq_addr got=%h exp=80001000", memreq.addr); end
      checks++; if (ireq.ready !== 1'b1 || dreq.ready !== 1'b0) begin failures++; $display("FAIL single_ready got=i%0b d%0b exp=i1 d0", ireq.ready, dreq.ready); end
      tick();
      drive_i(1'b0, '0, 1'b0, '0);
      tick();
      tick();
      memresp.valid = 1'b1;
      memresp.rdata = 32'h2000_0C01;
      settle();
      checks++; if (iresp.valid !== 1'b1) begin failures++; $display("FAIL single_iresp_valid got=%0b exp=1", iresp.valid); end
      checks++; if (iresp.rdata !== 32'h2000_0C01) begin failures++; $display("FAIL single_iresp_rdata got=%h exp=20000c01", iresp.rdata); end
      checks++; if (dresp.valid !== 1'b0) begin failures++; $display("FAIL single_dresp_valid got=%0b exp=0", dresp.valid); end
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL single_protocol_err got=%0b exp=0", protocol_err); end
      tick();
      memresp.valid = 1'b0;
      settle();
      checks++; if (iresp.valid !== 1'b0) begin failures++; $display("FAIL single_iresp_pulse got=%0b exp=0", iresp.valid); end
   endtask

   task automatic test_round_robin();
      ArbId exp_g [4];
      exp_g = '{ARB_D, ARB_I, ARB_D, ARB_I};
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         tick();
         memreq.ready = 1'b1;
         drive_i(k < 4, 32'hA000_0000, 1'b0, '0);
         drive_d(k < 4, 32'hB000_0000, 1'b0, '0);
         memresp.valid = (k >= 1);
         memresp.rdata = 32'h100 + k;
         settle();
         if (k < 4) begin
            checks++; if (ireq.ready !== (exp_g[k] == ARB_I) || dreq.ready !== (exp_g[k] == ARB_D)) begin failures++; $display("FAIL rr_grant_%0d got=i%0b d%0b exp=%s", k, ireq.ready, dreq.ready, exp_g[k].name()); end
            checks++; if (memreq.addr !== ((exp_g[k] == ARB_I) ? 32'hA000_0000 : 32'hB000_0000)) begin failures++; $display("FAIL rr_addr_%0d got=%h exp_side=%s", k, memreq.addr, exp_g[k].name()); end
         end
         if (k >= 1) begin
            checks++; if (iresp.valid !== (exp_g[k-1] == ARB_I) || dresp.valid !== (exp_g[k-1] == ARB_D)) begin failures++; $display("FAIL rr_resp_%0d got=i%0b d%0b exp=%s", k, iresp.valid, dresp.valid, exp_g[k-1].name()); end
         end
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_lock_stall();
      apply_reset();
      tick();
      // A D write first makes round-robin favour I, so only the lock keeps D selected.
      drive_d(1'b1, 32'hD000_0004, 1'b1, 32'h1);
      memreq.ready = 1'b1;
      settle();
      checks++; if (dreq.ready !== 1'b1) begin failures++; $display("FAIL lock_prewrite_ready got=%0b exp=1", dreq.ready); end
      for (int c = 1; c <= 8; c++) begin
         tick();
         drive_d(c <= 5, 32'hD000_0000, 1'b0, '0);
         drive_i(c >= 2 && c <= 6, 32'hA000_0040, 1'b0, '0);
         memreq.ready = (c >= 5);
         memresp.valid = (c >= 7);
         settle();
         if (c <= 5) begin
            checks++; if (memreq.valid !== 1'b1 || memreq.addr !== 32'hD000_0000) begin failures++; $display("FAIL lock_hold_%0d got=v%0b a%h exp=v1 ad0000000", c, memreq.valid, memreq.addr); end
            checks++; if (ireq.ready !== 1'b0 || dreq.ready !== (c == 5)) begin failures++; $display("FAIL lock_ready_%0d got=i%0b d%0b exp=i0 d%0b", c, ireq.ready, dreq.ready, c == 5); end
         end else if (c == 6) begin
            checks++; if (ireq.ready !== 1'b1 || memreq.addr !== 32'hA000_0040) begin failures++; $display("FAIL lock_then_i got=r%0b a%h exp=r1 aa0000040", ireq.ready, memreq.addr); end
         end else begin
            checks++; if (dresp.valid !== (c == 7) || iresp.valid !== (c == 8)) begin failures++; $display("FAIL lock_resp_%0d got=i%0b d%0b", c, iresp.valid, dresp.valid); end
         end
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_full_gating();
      apply_reset();
      for (int c = 0; c <= 7; c++) begin
         tick();
         memreq.ready = 1'b1;
         drive_i(c <= 5, 32'hA000_0100 + 32'(4 * ((c < 2) ? c : 2)), 1'b0, '0);
         drive_d(c == 3, 32'hD000_0008, 1'b1, 32'h2000_0CC1);
         memresp.valid = (c == 4 || c >= 6);
         settle();
         case (c)
            0, 1: begin
               checks++; if (ireq.ready !== 1'b1) begin failures++; $display("FAIL full_read_%0d got=%0b exp=1", c, ireq.ready); end
            end
            2: begin
               checks++; if (ireq.ready !== 1'b0 || memreq.valid !== 1'b0) begin failures++; $display("FAIL full_stall got=r%0b v%0b exp=r0 v0", ireq.ready, memreq.valid); end
            end
            3: begin
               checks++; if (dreq.ready !== 1'b1 || ireq.ready !== 1'b0) begin failures++; $display("FAIL full_write_ready got=d%0b i%0b exp=d1 i0", dreq.ready, ireq.ready); end
               checks++; if (memreq.wen !== 1'b1 || memreq.wdata !== 32'h2000_0CC1) begin failures++; $display("FAIL full_write_data got=w%0b d%h exp=w1 d20000cc1", memreq.wen, memreq.wdata); end
            end
            4: begin
               checks++; if (iresp.valid !== 1'b1 || ireq.ready !== 1'b0) begin failures++; $display("FAIL full_pop_no_bypass got=resp%0b rdy%0b exp=resp1 rdy0", iresp.valid, ireq.ready); end
            end
            5: begin
               checks++; if (ireq.ready !== 1'b1) begin failures++; $display("FAIL full_unblock got=%0b exp=1", ireq.ready); end
            end
            default: begin
               checks++; if (iresp.valid !== 1'b1) begin failures++; $display("FAIL full_drain_%0d got=%0b exp=1", c, iresp.valid); end
            end
         endcase
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_protocol_err();
      apply_reset();
      tick();
      memresp.valid = 1'b1;
      memresp.rdata = 32'hDEAD_BEEF;
      settle();
      checks++; if (iresp.valid !== 1'b0 || dresp.valid !== 1'b0) begin failures++; $display("FAIL perr_drop got=i%0b d%0b exp=i0 d0", iresp.valid, dresp.valid); end
      tick();
      memresp.valid = 1'b0;
      settle();
      checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL perr_set got=%0b exp=1", protocol_err); end
      for (int c = 0; c < 3; c++) begin
         tick();
         memreq.ready = 1'b1;
         drive_i(1'b1, 32'hA000_0200 + 32'(4 * c), 1'b0, '0);
         settle();
      end
      checks++; if (ireq.ready !== 1'b0 || protocol_err !== 1'b1) begin failures++; $display("FAIL perr_sticky_full got=r%0b e%0b exp=r0 e1", ireq.ready, protocol_err); end
      tick();
      reset = 1'b1;
      idle_inputs();
      tick();
      reset = 1'b0;
      settle();
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL perr_cleared got=%0b exp=0", protocol_err); end
      // Two reads accepted back to back shows the stale entries were discarded.
      for (int c = 0; c < 2; c++) begin
         tick();
         memreq.ready = 1'b1;
         drive_i(1'b1, 32'hA000_0300 + 32'(4 * c), 1'b0, '0);
         settle();
         checks++; if (ireq.ready !== 1'b1) begin failures++; $display("FAIL perr_count_cleared_%0d got=%0b exp=1", c, ireq.ready); end
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         drive_i(1'b0, '0, 1'b0, '0);
         memresp.valid = 1'b1;
         settle();
         checks++; if (iresp.valid !== 1'b1) begin failures++; $display("FAIL perr_drain_%0d got=%0b exp=1", c, iresp.valid); end
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_random();
      ArbId             m_q [$];
      ArbId             m_last, held_id, win;
      logic             held, rdy, rv, w_valid, w_wen, e_valid, e_acc;
      logic             pi_v, pi_w, pd_v, pd_w;
      logic [AddrW-1:0] pi_a, pd_a, w_addr;
      logic [DataW-1:0] pi_d, pd_d, r_data;
      logic [1:0]       r_ty;
      apply_reset();
      m_last = ARB_I; held = 1'b0; held_id = ARB_I;
      pi_v = 1'b0; pd_v = 1'b0; pi_w = 1'b0; pd_w = 1'b0;
      pi_a = '0; pd_a = '0; pi_d = '0; pd_d = '0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (!pi_v && $urandom_range(0, 1) == 1) begin
            pi_v = 1'b1; pi_w = ($urandom_range(0, 3) == 0); pi_a = $urandom; pi_d = $urandom;
         end
         if (!pd_v && $urandom_range(0, 1) == 1) begin
            pd_v = 1'b1; pd_w = ($urandom_range(0, 3) == 0); pd_a = $urandom; pd_d = $urandom;
         end
         drive_i(pi_v, pi_a, pi_w, pi_d);
         drive_d(pd_v, pd_a, pd_w, pd_d);
         rdy = ($urandom_range(0, 2) != 0);
         rv = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
         r_data = $urandom;
         r_ty = 2'($urandom_range(0, 3));
         memreq.ready = rdy;
         memresp.valid = rv;
         memresp.rdata = r_data;
         memresp.error = r_ty[0];
         memresp.errty = r_ty;
         // Reference: a stalled request keeps the port; otherwise alternate on conflict.
         if (held) win = held_id;
         else if (pi_v && pd_v) win = (m_last == ARB_I) ? ARB_D : ARB_I;
         else win = pd_v ? ARB_D : ARB_I;
         w_valid = (win == ARB_D) ? pd_v : pi_v;
         w_wen = (win == ARB_D) ? pd_w : pi_w;
         w_addr = (win == ARB_D) ? pd_a : pi_a;
         e_valid = w_valid && !(!w_wen && m_q.size() == Depth);
         e_acc = e_valid && rdy;
         settle();
         checks++; if (memreq.valid !== e_valid) begin failures++; $display("FAIL rnd_memreq_valid n=%0d got=%0b exp=%0b", n, memreq.valid, e_valid); end
         checks++; if (ireq.ready !== (e_acc && win == ARB_I) || dreq.ready !== (e_acc && win == ARB_D)) begin failures++; $display("FAIL rnd_ready n=%0d got=i%0b d%0b exp_acc=%0b side=%s", n, ireq.ready, dreq.ready, e_acc, win.name()); end
         if (e_valid) begin
            checks++; if (memreq.addr !== w_addr || memreq.wen !== w_wen) begin failures++; $display("FAIL rnd_mux n=%0d got=a%h w%0b exp=a%h w%0b", n, memreq.addr, memreq.wen, w_addr, w_wen); end
         end
         checks++; if (iresp.valid !== (rv && m_q[0] == ARB_I) || dresp.valid !== (rv && m_q[0] == ARB_D)) begin failures++; $display("FAIL rnd_resp n=%0d got=i%0b d%0b exp_valid=%0b", n, iresp.valid, dresp.valid, rv); end
         if (rv) begin
            checks++; if (iresp.rdata !== r_data || dresp.rdata !== r_data || dresp.errty !== r_ty || iresp.error !== r_ty[0]) begin failures++; $display("FAIL rnd_bcast n=%0d got=%h/%h ty%0d exp=%h ty%0d", n, iresp.rdata, dresp.rdata, dresp.errty, r_data, r_ty); end
            void'(m_q.pop_front());
         end
         if (e_acc) begin
            m_last = win;
            if (!w_wen) m_q.push_back(win);
            if (win == ARB_I) pi_v = 1'b0;
            else pd_v = 1'b0;
         end
         held = e_valid && !rdy;
         held_id = win;
      end
      while (m_q.size() != 0) begin
         tick();
         idle_inputs();
         memresp.valid = 1'b1;
         settle();
         checks++; if (iresp.valid !== (m_q[0] == ARB_I) || dresp.valid !== (m_q[0] == ARB_D)) begin failures++; $display("FAIL rnd_drain got=i%0b d%0b exp=%s", iresp.valid, dresp.valid, m_q[0].name()); end
         void'(m_q.pop_front());
      end
      tick();
      idle_inputs();
      settle();
      checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL rnd_protocol_err got=%0b exp=0", protocol_err); end
   endtask

`ifdef PTW_ARB_PERFCNT_EN
   task automatic test_perfcnt();
      apply_reset();
      for (int c = 0; c < 8; c++) begin
         tick();
         memreq.ready = 1'b1;
         drive_i(c <= 5, 32'hA000_0400, 1'b1, 32'h11);
         drive_d(c <= 1 || c >= 6, 32'hD000_0400, 1'b1, 32'h22);
         settle();
      end
      tick();
      idle_inputs();
      settle();
      checks++; if (perf_igrant !== 32'd5) begin failures++; $display("FAIL perf_igrant got=%0d exp=5", perf_igrant); end
      checks++; if (perf_dgrant !== 32'd3) begin failures++; $display("FAIL perf_dgrant got=%0d exp=3", perf_dgrant); end
      checks++; if (perf_conflict !== 32'd2) begin failures++; $display("FAIL perf_conflict got=%0d exp=2", perf_conflict); end
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock_stall();
      test_full_gating();
      test_protocol_err();
      test_random();
`ifdef PTW_ARB_PERFCNT_EN
      test_perfcnt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
